// File: rtl/core_run_ctrl.sv
// -----------------------------------------------------------------------------
// core_run_ctrl
//
// Host-side run controller for the core's req/done start handshake. For each
// program it holds the core in reset, issues a one-cycle req pulse, then waits
// for done while a watchdog counts cycles. Each run ends in a latched report
// that the host must acknowledge before the next program is started.
//
// Ports:
//   clk          single clock
//   reset        asynchronous, active-low reset
//   start        host start, sampled only in IDLE
//   num_progs    programs to run (1..3, 0 treated as 1), latched on start
//   abort        host abort, acts from any non-IDLE state
//   core_reset   active-high reset driven to the core
//   req          one-cycle start pulse to the core
//   done         core completion level
//   prog_sel     index of the current program
//   busy         high in every state except IDLE
//   rpt_valid    report available
//   rpt_ack      host acknowledge of the report
//   rpt_cycles   WAIT cycles counted for the run
//   rpt_timeout  run ended on the watchdog limit
//   rpt_prog     program index the report belongs to
//   all_done     one-cycle pulse after the last report is acknowledged
// -----------------------------------------------------------------------------
module core_run_ctrl #(
   parameter int unsigned   CW         = 16,
   parameter logic [CW-1:0] MAX_CYCLES = 16'd50000,
   parameter int unsigned   RST_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    num_progs,
   input  logic          abort,
   output logic          core_reset,
   output logic          req,
   input  logic          done,
   output logic [1:0]    prog_sel,
   output logic          busy,
   output logic          rpt_valid,
   input  logic          rpt_ack,
   output logic [CW-1:0] rpt_cycles,
   output logic          rpt_timeout,
   output logic [1:0]    rpt_prog,
   output logic          all_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_REQ,
      S_WAIT,
      S_REPORT
   } state_t;

   // RST counter only needs to reach RST_CYCLES-1.
   localparam int unsigned     RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYCLES - 1);

   state_t          state_q, state_d;
   logic [RCW-1:0]  rst_cnt_q, rst_cnt_d;
   logic [CW-1:0]   cyc_cnt_q, cyc_cnt_d;
   logic [CW-1:0]   cyc_inc;
   logic [1:0]      nprog_q, nprog_d;
   logic [1:0]      prog_sel_d;
   logic [CW-1:0]   rpt_cycles_d;
   logic            rpt_timeout_d;
   logic [1:0]      rpt_prog_d;
   logic            all_done_d;
   logic            kill;

   // Next-state and next-register logic.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves
      // a combinational output unassigned and no latch is inferred.
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      cyc_cnt_d     = cyc_cnt_q;
      nprog_d       = nprog_q;
      prog_sel_d    = prog_sel;
      rpt_cycles_d  = rpt_cycles;
      rpt_timeout_d = rpt_timeout;
      rpt_prog_d    = rpt_prog;
      all_done_d    = 1'b0;
      kill          = 1'b0;
      cyc_inc       = cyc_cnt_q + 1'b1;

      if (abort) begin
         // Abort beats start, done, ack and the watchdog. In IDLE it simply
         // suppresses a simultaneous start.
         state_d = S_IDLE;
         kill    = (state_q != S_IDLE);
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_RST;
                  nprog_d    = (num_progs == 2'd0) ? 2'd1 : num_progs;
                  prog_sel_d = 2'd0;
                  rst_cnt_d  = '0;
               end
            end
            S_RST: begin
               if (rst_cnt_q == RST_LAST) state_d = S_REQ;
               else                       rst_cnt_d = rst_cnt_q + 1'b1;
            end
            S_REQ: begin
               state_d   = S_WAIT;
               cyc_cnt_d = '0;
            end
            S_WAIT: begin
               cyc_cnt_d = cyc_inc;
               // done is checked first so it wins on the limit cycle.
               if (done) begin
                  state_d       = S_REPORT;
                  rpt_cycles_d  = cyc_inc;
                  rpt_timeout_d = 1'b0;
                  rpt_prog_d    = prog_sel;
               end else if (cyc_inc == MAX_CYCLES) begin
                  state_d       = S_REPORT;
                  rpt_cycles_d  = MAX_CYCLES;
                  rpt_timeout_d = 1'b1;
                  rpt_prog_d    = prog_sel;
               end
            end
            S_REPORT: begin
               if (rpt_ack) begin
                  if (prog_sel < nprog_q - 2'd1) begin
                     state_d    = S_RST;
                     prog_sel_d = prog_sel + 2'd1;
                     rst_cnt_d  = '0;
                  end else begin
                     state_d    = S_IDLE;
                     all_done_d = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and registered outputs. Outputs are decoded from the next state so
   // they line up with the state they describe, with no input-to-output path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         cyc_cnt_q   <= '0;
         nprog_q     <= 2'd1;
         prog_sel    <= 2'd0;
         rpt_cycles  <= '0;
         rpt_timeout <= 1'b0;
         rpt_prog    <= 2'd0;
         core_reset  <= 1'b0;
         req         <= 1'b0;
         busy        <= 1'b0;
         rpt_valid   <= 1'b0;
         all_done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // values computed from the same pre-edge state.
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         cyc_cnt_q   <= cyc_cnt_d;
         nprog_q     <= nprog_d;
         prog_sel    <= prog_sel_d;
         rpt_cycles  <= rpt_cycles_d;
         rpt_timeout <= rpt_timeout_d;
         rpt_prog    <= rpt_prog_d;
         // Hold the core in reset for the cycle after an abort so it stops
         // driving memory.
         core_reset  <= kill || (state_d == S_RST);
         req         <= (state_d == S_REQ);
         busy        <= (state_d != S_IDLE);
         rpt_valid   <= (state_d == S_REPORT);
         all_done    <= all_done_d;
      end
   end

endmodule

// File: tb/tb_core_run_ctrl.sv
module tb_core_run_ctrl;

   localparam int R    = 2;
   localparam int MAXC = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort, done, rpt_ack;
   logic [1:0]  num_progs;
   logic        core_reset, req, busy, rpt_valid, rpt_timeout, all_done;
   logic [1:0]  prog_sel, rpt_prog;
   logic [15:0] rpt_cycles;

   // Second instance for the MAX_CYCLES=1 boundary.
   logic        s1, d1, a1;
   logic        cr1, rq1, bz1, rv1, rt1, ad1;
   logic [1:0]  ps1, rp1;
   logic [15:0] rc1;

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: what the report registers and prog_sel should hold.
   int          m_prog;
   logic [15:0] lr_cyc;
   logic        lr_to;
   logic [1:0]  lr_prog;
   int          ack_fix     = -1;
   bit          force_stale = 1'b0;

   always #5 clk = ~clk;

   core_run_ctrl #(.CW(16), .MAX_CYCLES(16'd20), .RST_CYCLES(R)) dut (
      .clk(clk), .reset(reset), .start(start), .num_progs(num_progs),
      .abort(abort), .core_reset(core_reset), .req(req), .done(done),
      .prog_sel(prog_sel), .busy(busy), .rpt_valid(rpt_valid),
      .rpt_ack(rpt_ack), .rpt_cycles(rpt_cycles), .rpt_timeout(rpt_timeout),
      .rpt_prog(rpt_prog), .all_done(all_done)
   );

   core_run_ctrl #(.CW(16), .MAX_CYCLES(16'd1), .RST_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .start(s1), .num_progs(2'd1),
      .abort(1'b0), .core_reset(cr1), .req(rq1), .done(d1),
      .prog_sel(ps1), .busy(bz1), .rpt_valid(rv1),
      .rpt_ack(a1), .rpt_cycles(rc1), .rpt_timeout(rt1),
      .rpt_prog(rp1), .all_done(ad1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_outs(input string tag, input logic cr, input logic rq,
                              input logic bz, input logic rv, input logic ad);
      check({tag, ".core_reset"},  core_reset,  cr);
      check({tag, ".req"},         req,         rq);
      check({tag, ".busy"},        busy,        bz);
      check({tag, ".rpt_valid"},   rpt_valid,   rv);
      check({tag, ".all_done"},    all_done,    ad);
      check({tag, ".prog_sel"},    prog_sel,    m_prog);
      check({tag, ".rpt_cycles"},  rpt_cycles,  lr_cyc);
      check({tag, ".rpt_timeout"}, rpt_timeout, lr_to);
      check({tag, ".rpt_prog"},    rpt_prog,    lr_prog);
   endtask

   task automatic noise();
      done    = force_stale ? 1'b1 : 1'($urandom_range(0, 1));
      start   = 1'($urandom_range(0, 1));
      rpt_ack = 1'($urandom_range(0, 1));
   endtask

   task automatic do_abort(input string tag);
      abort = 1'b1;
      start = 1'($urandom_range(0, 1));
      tick();
      abort = 1'b0; start = 1'b0; rpt_ack = 1'b0; done = 1'b0;
      expect_outs(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      expect_outs({tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic int rand_lat();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30))
                                         : int'($urandom_range(0, 12));
   endfunction

   // One host job: start, then per program RST/REQ/WAIT/REPORT with the
   // expected report derived from the done latency and the watchdog limit.
   // ab_phase: 0 = abort in RST, 1 = abort in WAIT, 2 = abort with ack in REPORT.
   task automatic run_job(input int np_in, input int l0, input int l1, input int l2,
                          input int ab_prog, input int ab_phase, input int ab_at);
      int np, lat, exp_cyc, dly;
      bit exp_to;
      np = (np_in == 0) ? 1 : np_in;
      abort   = 1'b0;
      rpt_ack = 1'($urandom_range(0, 1));
      done    = 1'($urandom_range(0, 1));
      start   = 1'b1;
      num_progs = 2'(np_in);
      tick();
      start = 1'b0;
      num_progs = 2'($urandom_range(0, 3));
      m_prog = 0;
      for (int p = 0; p < np; p++) begin
         lat = (p == 0) ? l0 : (p == 1) ? l1 : l2;
         if (lat + 1 <= MAXC) begin
            exp_cyc = lat + 1; exp_to = 1'b0;
         end else begin
            exp_cyc = MAXC;    exp_to = 1'b1;
         end
         for (int i = 0; i < R; i++) begin
            expect_outs("rst", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            if (p == ab_prog && ab_phase == 0 && i == ab_at % R) begin
               do_abort("abort_rst");
               return;
            end
            noise();
            tick();
         end
         expect_outs("req", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         noise();
         tick();
         for (int k = 0; k < exp_cyc; k++) begin
            expect_outs("wait", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (p == ab_prog && ab_phase == 1 && k == ab_at % exp_cyc) begin
               do_abort("abort_wait");
               return;
            end
            done    = (k >= lat);
            start   = 1'($urandom_range(0, 1));
            rpt_ack = 1'($urandom_range(0, 1));
            tick();
         end
         lr_cyc  = 16'(exp_cyc);
         lr_to   = exp_to;
         lr_prog = 2'(p);
         dly = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 4));
         for (int j = 0; j < dly; j++) begin
            expect_outs("rpt_hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            rpt_ack = 1'b0;
            done    = 1'($urandom_range(0, 1));
            start   = 1'($urandom_range(0, 1));
            tick();
         end
         expect_outs("rpt", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         if (p == ab_prog && ab_phase == 2) begin
            rpt_ack = 1'b1;
            do_abort("abort_rpt");
            return;
         end
         rpt_ack = 1'b1;
         start   = 1'($urandom_range(0, 1));
         done    = 1'($urandom_range(0, 1));
         tick();
         rpt_ack = 1'b0;
         start   = 1'b0;
         if (p < np - 1) begin
            m_prog = p + 1;
         end else begin
            expect_outs("last_ack", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            expect_outs("idle_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; done = 1'b0; rpt_ack = 1'b0;
      num_progs = 2'd0; s1 = 1'b0; d1 = 1'b0; a1 = 1'b0;
      m_prog = 0; lr_cyc = '0; lr_to = 1'b0; lr_prog = 2'd0;
      #2;
      expect_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      rpt_ack = 1'b1;
      tick();
      rpt_ack = 1'b0;
      expect_outs("idle_ack_ignored", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start and abort together in IDLE: stay idle, no core reset.
      start = 1'b1; abort = 1'b1; num_progs = 2'd3;
      tick();
      start = 1'b0; abort = 1'b0;
      expect_outs("start_abort_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // MAX_CYCLES=1 instance: done on the limit cycle wins, then timeout.
      d1 = 1'b1; s1 = 1'b1;
      tick(); s1 = 1'b0;
      check("m1.core_reset", cr1, 1'b1);
      tick();
      check("m1.req", rq1, 1'b1);
      tick();
      tick();
      check("m1.rpt_valid", rv1, 1'b1);
      check("m1.rpt_cycles", rc1, 16'd1);
      check("m1.rpt_timeout", rt1, 1'b0);
      a1 = 1'b1; tick(); a1 = 1'b0;
      check("m1.all_done", ad1, 1'b1);
      d1 = 1'b0; s1 = 1'b1;
      tick(); s1 = 1'b0;
      tick(); tick(); tick();
      check("m1.to_valid", rv1, 1'b1);
      check("m1.to_cycles", rc1, 16'd1);
      check("m1.to_timeout", rt1, 1'b1);
      a1 = 1'b1; tick(); a1 = 1'b0;
      check("m1.to_all_done", ad1, 1'b1);

      // Directed runs.
      run_job(1, 10, 0, 0, -1, 0, 0);        // rpt_cycles 11
      run_job(1, 40, 0, 0, -1, 0, 0);        // timeout at 20
      run_job(1, 19, 0, 0, -1, 0, 0);        // done on the limit cycle
      ack_fix = 3;
      run_job(3, 5, 0, 7, -1, 0, 0);         // 6, 1, 8
      ack_fix = -1;
      force_stale = 1'b1;
      run_job(2, 0, 3, 0, -1, 0, 0);         // stale done ignored
      force_stale = 1'b0;
      run_job(1, 10, 0, 0, 0, 1, 4);         // abort at count 4
      run_job(0, 2, 0, 0, -1, 0, 0);         // num_progs 0 acts as 1
      run_job(2, 3, 4, 0, 1, 2, 0);          // abort together with ack

      // Asynchronous reset mid-REQ, away from any clock edge.
      start = 1'b1; num_progs = 2'd2;
      tick(); start = 1'b0; m_prog = 0;
      tick(); tick();
      expect_outs("pre_async", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      m_prog = 0; lr_cyc = '0; lr_to = 1'b0; lr_prog = 2'd0;
      expect_outs("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      tick(); tick();
      expect_outs("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized jobs.
      for (int j = 0; j < 40; j++) begin
         int ab_prog;
         ab_prog = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
         run_job(int'($urandom_range(0, 3)), rand_lat(), rand_lat(), rand_lat(),
                 ab_prog, int'($urandom_range(0, 2)), int'($urandom_range(0, 25)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
